// File: rtl/branch_history_unit_pkg.sv
`default_nettype none
// ============================================================================
// branch_history_unit_pkg
// Shared predictor definitions: history geometry, PHT counter states, slot.
// Revision: 1.0
// ============================================================================
package branch_history_unit_pkg;

    localparam int HIST_WIDTH = 4;
    localparam int PC_LSB     = 2;

    typedef enum logic [1:0] {
        STRONGLY_NOT_TAKEN = 2'b00,
        WEAKLY_NOT_TAKEN   = 2'b01,
        WEAKLY_TAKEN       = 2'b10,
        STRONGLY_TAKEN     = 2'b11
    } pht_state_t;

    // Branch carried from IF/ID to ID/EX together with its PHT index.
    typedef struct packed {
        logic                  valid;
        logic [HIST_WIDTH-1:0] index;
        logic                  pred;
    } slot_t;

    function automatic logic [HIST_WIDTH-1:0] hash_index(
        input logic [HIST_WIDTH-1:0] hist,
        input logic [31:0]           pc
    );
        return hist ^ pc[PC_LSB +: HIST_WIDTH];
    endfunction

endpackage : branch_history_unit_pkg
`default_nettype wire

// File: rtl/branch_history_unit_ghr_shift.sv
`default_nettype none
// ============================================================================
// ghr_shift
// History shift register with shift-in bit and a priority parallel load.
// Revision: 1.0
// ============================================================================
module ghr_shift #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             shift_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] hist
);

    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
        end else if (load_en) begin
            r_hist <= load_val;
        end else if (shift_en) begin
            r_hist <= {r_hist[WIDTH-2:0], shift_in};
        end
    end

    assign hist = r_hist;

endmodule : ghr_shift
`default_nettype wire

// File: rtl/branch_history_unit.sv
`default_nettype none
// ============================================================================
// branch_history_unit
// GHR-hashed PHT index generator, branch slot, mispredict repair and stats.
// Revision: 1.0
// ============================================================================
module branch_history_unit
    import branch_history_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           IF_ID_PC,
    input  logic                  IF_ID_Branch,
    input  logic                  IF_ID_Write,
    input  logic                  Flush,
    input  logic                  BPred,
    input  logic                  BPredValid,
    input  logic                  ID_EX_Branch,
    input  logic                  PCSrc,
    output logic                  PHTrd,
    output logic [HIST_WIDTH-1:0] PHT_index,
    output logic [HIST_WIDTH-1:0] PHT_Windex,
    output logic                  Mispredict,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [HIST_WIDTH-1:0] w_spec_hist;
    logic [HIST_WIDTH-1:0] w_arch_hist;
    logic [HIST_WIDTH-1:0] w_repair_hist;
    logic                  w_pred;
    logic                  w_accept;
    logic                  w_resolve;
    logic                  w_mispredict;
    slot_t                 r_slot;
    slot_t                 w_slot_next;
    logic [CNT_WIDTH-1:0]  r_branch_cnt;
    logic [CNT_WIDTH-1:0]  r_mispred_cnt;

    assign w_pred        = BPredValid & BPred;
    assign w_accept      = IF_ID_Branch & IF_ID_Write & ~Flush;
    assign w_resolve     = ID_EX_Branch & r_slot.valid;
    assign w_mispredict  = w_resolve & (PCSrc != r_slot.pred);
    // Committed history including the branch resolving this cycle.
    assign w_repair_hist = {w_arch_hist[HIST_WIDTH-2:0], PCSrc};

    assign PHTrd      = IF_ID_Branch;
    assign PHT_index  = hash_index(w_spec_hist, IF_ID_PC);
    assign PHT_Windex = r_slot.index;
    assign Mispredict = w_mispredict;

    // Repair load has priority over a same-cycle speculative shift.
    ghr_shift #(
        .WIDTH (HIST_WIDTH)
    ) u_spec_hist (
        .clk      (clk),
        .rst_n    (reset),
        .shift_en (w_accept),
        .shift_in (w_pred),
        .load_en  (w_mispredict),
        .load_val (w_repair_hist),
        .hist     (w_spec_hist)
    );

    ghr_shift #(
        .WIDTH (HIST_WIDTH)
    ) u_arch_hist (
        .clk      (clk),
        .rst_n    (reset),
        .shift_en (w_resolve),
        .shift_in (PCSrc),
        .load_en  (1'b0),
        .load_val ({HIST_WIDTH{1'b0}}),
        .hist     (w_arch_hist)
    );

    // A resolved slot is retired even while IF/ID is stalled.
    always_comb begin
        w_slot_next = r_slot;
        if (w_resolve) begin
            w_slot_next.valid = 1'b0;
        end
        if (Flush) begin
            w_slot_next.valid = 1'b0;
        end else if (IF_ID_Write) begin
            if (w_accept) begin
                w_slot_next.valid = 1'b1;
                w_slot_next.index = PHT_index;
                w_slot_next.pred  = w_pred;
            end else begin
                w_slot_next.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slot <= '0;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_resolve && (r_branch_cnt != {CNT_WIDTH{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + c_cnt_one;
            end
            if (w_mispredict && (r_mispred_cnt != {CNT_WIDTH{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + c_cnt_one;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule : branch_history_unit
`default_nettype wire

// File: doc/branch_history_unit.md
# branch_history_unit

Global-history index generator and outcome tracker that drives the Pattern History Table. It hashes the fetch PC with a speculative global history register (GHR) to form the PHT read index, and carries that index with each branch from IF/ID to ID/EX. At resolution it supplies the PHT write index, detects mispredicts, and repairs the speculative history from the committed history. It sits between the IF/ID register, the PHT, and the EX-stage branch comparator.

## Interface
- `HIST_WIDTH`, 4: GHR length; also the PHT index width.
- `PC_LSB`, 2: lowest PC bit used in the hash.
- `CNT_WIDTH`, 16: width of the statistics counters.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IF_ID_PC`  in  32  PC of the instruction in IF/ID.
- `IF_ID_Branch`  in  1  the IF/ID instruction is a branch with a BTB hit.
- `IF_ID_Write`  in  1  IF/ID advance enable; 0 = stall.
- `Flush`  in  1  squash the younger in-flight branch slot.
- `BPred`  in  1  prediction returned by the PHT.
- `BPredValid`  in  1  the PHT prediction is valid.
- `ID_EX_Branch`  in  1  ID/EX holds a resolving branch.
- `PCSrc`  in  1  actual branch outcome, 1 = taken.
- `PHTrd`  out  1  PHT read enable.
- `PHT_index`  out  HIST_WIDTH  PHT read index.
- `PHT_Windex`  out  HIST_WIDTH  PHT write index.
- `Mispredict`  out  1  resolved outcome differs from the carried prediction.
- `branch_cnt`  out  CNT_WIDTH  count of resolved branches.
- `mispred_cnt`  out  CNT_WIDTH  count of mispredicts.

## Operation
- **Read side (combinational)**
  - `PHT_index = spec_hist ^ IF_ID_PC[PC_LSB +: HIST_WIDTH]`.
  - `PHTrd = IF_ID_Branch`.
- **Effective prediction:** `pred = BPredValid & BPred`. An invalid prediction counts as not-taken.
- **Fetch-side update:** when `IF_ID_Branch & IF_ID_Write & ~Flush` is high:
  - `spec_hist <= {spec_hist[HIST_WIDTH-2:0], pred}`.
  - Slot captures `{valid=1, index=PHT_index, pred}`.
- **Slot advance:**
  - If `IF_ID_Write` is high and no branch is accepted, slot valid <= 0.
  - If `IF_ID_Write` is low, the slot holds its contents.
  - If `Flush` is high, slot valid <= 0.
- **Write side**
  - `PHT_Windex = slot.index`, always driven.
  - `Mispredict = ID_EX_Branch & slot.valid & (PCSrc != slot.pred)`, combinational.
- **Resolution:** on `ID_EX_Branch & slot.valid`:
  - `arch_hist <= {arch_hist[HIST_WIDTH-2:0], PCSrc}`.
  - `branch_cnt` increments.
  - If `Mispredict` is high, `mispred_cnt` increments and `spec_hist <= {arch_hist[HIST_WIDTH-2:0], PCSrc}`.
- **Counters:** saturate at all-ones and never wrap.
- **Reset values:** `spec_hist`, `arch_hist`, the slot and both counters clear to 0. `Mispredict` is 0. `PHT_index` equals the masked PC bits.
- **Resolution without a slot:** `ID_EX_Branch` with slot valid = 0 (e.g. the branch was flushed, or there was no BTB hit) is ignored. No counter or history change.

## Timing
- `PHT_index` and `PHTrd` are valid in the same cycle as `IF_ID_PC` (zero latency).
- The speculative history shift becomes visible on `PHT_index` in the cycle after a branch is accepted.
- Slot latency is exactly one advancing cycle (IF/ID to ID/EX). `PHT_Windex` and `Mispredict` are valid in the cycle `ID_EX_Branch` is high, aligned with the PHT's update edge.
- **Simultaneous accept and mispredict:** the mispredict repair wins; `spec_hist` takes the repaired value.
  - If the flushed fetch is a branch, it is not captured because `Flush` accompanies the mispredict.
  - If `Flush` is low, the new branch is still captured into the slot, with its index computed from the pre-repair history.
- **Stall with resolution:** resolution in a stall cycle happens once. After a resolution, slot valid clears regardless of `IF_ID_Write`, so a held slot cannot double-count.
- **Reset:** `reset` low mid-operation clears all state asynchronously. The first edge after release behaves as post-reset.

## Structure
- Shared predictor package holds:
  - `HIST_WIDTH`, `PC_LSB`;
  - the 2-bit counter encodings (`STRONGLY_NOT_TAKEN`..`STRONGLY_TAKEN`);
  - a slot struct `{valid, index, pred}`.
- One sub-module, `ghr_shift`: a HIST_WIDTH shift register with a shift-in bit, a load port (for repair) and async reset, instantiated twice (speculative and architectural).
- Hash, slot, mispredict logic and counters live in the top.

## Test plan
- **Reset:** hold `reset`=0 with `IF_ID_PC`=0x0000_0034 and `IF_ID_Branch`=1 → `PHT_index`=4'hD, `PHTrd`=1, `Mispredict`=0, both counters 0.
- **Correct prediction:** branch at PC 0x40 with `BPred`=1, `BPredValid`=1; next cycle `ID_EX_Branch`=1, `PCSrc`=1 → `PHT_Windex`=4'h0, `Mispredict`=0, `branch_cnt`=1, `spec_hist`=`arch_hist`=4'b0001.
- **Mispredict repair:** with `arch_hist`=4'b0101 and `spec_hist`=4'b1011, a slot with pred=1 resolves `PCSrc`=0 → `Mispredict`=1; next cycle `spec_hist`=4'b1010 and `mispred_cnt`=1.
- **Invalid prediction:** `BPredValid`=0, `BPred`=1, then resolve `PCSrc`=1 → pred treated as 0, `Mispredict`=1.
- **Stall and flush:** capture a branch, then hold `IF_ID_Write`=0 for 3 cycles → `PHT_Windex` is stable. Assert `Flush` → a following `ID_EX_Branch` leaves the counters unchanged.
- **Saturation:** drive 0xFFFF+2 mispredicts → `mispred_cnt` holds 0xFFFF.
